fifo_rd_streamer: RTL

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_rd_streamer_skid_buf2.sv | 64 ++++++
 rtl/fifo_rd_streamer.sv | 70 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read streamer slice.
// Holds the output-buffer occupancy encoding and the delivered-word counter width.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int unsigned CNT_W = 16;

endpackage : fifo_pkg

// File: rtl/fifo_rd_streamer_skid_buf2.sv
// skid_buf2: two-entry in-order output buffer with occupancy state.
// slot0 always holds the oldest word and drives head_data.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output occ_t             occupancy
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    // Occupancy FSM plus entry storage; simultaneous push/pop keeps the level and order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= EMPTY;
            slot0     <= '0;
            slot1     <= '0;
        end else begin
            case (occupancy)
                EMPTY: begin
                    if (push) begin
                        slot0     <= push_data;
                        occupancy <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1     <= push_data;
                        occupancy <= TWO;
                    end else if (pop) begin
                        occupancy <= EMPTY;
                    end
                end
                TWO: begin
                    // push without pop cannot happen here: the read gate upstream reserves space
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) begin
                            slot1 <= push_data;
                        end else begin
                            occupancy <= ONE;
                        end
                    end
                end
                default: begin
                    occupancy <= EMPTY;
                end
            endcase
        end
    end

    assign head_data = slot0;

endmodule : skid_buf2

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a Sync_FIFO with a registered read port into a
// valid/ready stream at full throughput using a two-entry output buffer.
// Optional macro FIFO_RD_CNT_EN adds the 16-bit word_count output.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_W-1:0] word_count
`endif
);

    logic       inflight;
    logic       pop;
    logic [2:0] level_next;
    occ_t       occupancy;

    // Track a FIFO read whose data appears on fifo_data this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Issue a read only when the buffer level after this cycle leaves room for its data;
    // reset gates the strobe so it drops in the same cycle reset asserts
    always_comb begin
        pop        = m_valid && m_ready;
        level_next = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en = !reset && !fifo_empty && (level_next < 3'd2);
    end

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (m_data),
        .occupancy (occupancy)
    );

    assign m_valid = (occupancy != EMPTY);

`ifdef FIFO_RD_CNT_EN
    // Count words accepted downstream; wraps at the counter width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + CNT_W'(1);
        end
    end
`endif

endmodule : fifo_rd_streamer
